// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the serial ALU controller: the FSM state encoding,
// the opcode constants understood by the attached ALU, and a small helper.
package alu_ctrl_pkg;

   // Frame-handling states of the controller.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_B    = 3'd1,
      WAIT_OP   = 3'd2,
      EXEC      = 3'd3,
      SEND      = 3'd4,
      WAIT_DONE = 3'd5
   } state_t;

   // Opcode values shared with the ALU (MIPS-style function codes).
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

   // True while the controller is waiting for the second or third byte of a frame.
   function automatic logic is_collecting(input state_t s);
      return (s == WAIT_B) || (s == WAIT_OP);
   endfunction

endpackage

// File: rtl/alu_ctrl_timer.sv
// Inter-byte timeout counter for alu_ctrl. Counts enabled cycles and flags
// expiry in the cycle where the count sits at TIMEOUT_CYCLES-1 without a
// clear. Only instantiated when ALU_CTRL_TIMEOUT_EN is defined.
module alu_ctrl_timer #(
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

   logic [NB_CNT-1:0] cnt_q;
   logic [NB_CNT-1:0] cnt_d;

   assign o_expire = i_enable && !i_clear && (cnt_q == CNT_LAST);

   // Next count: restart on clear or when idle, wrap to zero on expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear || !i_enable) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + NB_CNT'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_ctrl.sv
// Serial front end for a combinational ALU: collects operand A, operand B and
// the opcode as three received bytes, captures the ALU result, and hands it to
// the transmitter. Optional inter-byte timeout enabled by macro
// ALU_CTRL_TIMEOUT_EN; without it o_error is constant 0 and the FSM waits
// indefinitely for the remaining bytes of a frame.
module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int NB_DATA        = 8,
   parameter int NB_AB          = 4,
   parameter int NB_OP          = 6,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_valid,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic [NB_AB-1:0]   o_alu_a,
   output logic [NB_AB-1:0]   o_alu_b,
   output logic [NB_OP-1:0]   o_alu_op,
   input  logic [NB_AB-1:0]   i_alu_result,
   output logic               o_busy,
   output logic               o_error
);

   // Reject parameterisations the byte slicing cannot honour.
   if ((NB_AB > NB_DATA) || (NB_OP > NB_DATA) || (NB_AB < 1) || (NB_OP < 1)
       || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("alu_ctrl: illegal parameter combination");
   end

   state_t             state_q, state_d;
   logic [NB_AB-1:0]   alu_a_q, alu_a_d;
   logic [NB_AB-1:0]   alu_b_q, alu_b_d;
   logic [NB_OP-1:0]   alu_op_q, alu_op_d;
   logic [NB_DATA-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               timeout_expire;

   // Upper bits of a received byte beyond the operand/opcode widths are
   // deliberately discarded.
   logic unused_rx_bits;
   assign unused_rx_bits = ^i_rx_data;

   assign o_alu_a    = alu_a_q;
   assign o_alu_b    = alu_b_q;
   assign o_alu_op   = alu_op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = (state_q != IDLE);

`ifdef ALU_CTRL_TIMEOUT_EN
   logic timer_enable;
   logic timer_clear;
   logic error_q, error_d;

   // The counter only runs mid-frame; any received strobe there is an
   // accepted byte and restarts it.
   assign timer_enable = is_collecting(state_q);
   assign timer_clear  = i_rx_valid;

   alu_ctrl_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_clear  (timer_clear),
      .i_enable (timer_enable),
      .o_expire (timeout_expire)
   );

   // The abort pulse follows the expiry cycle by one clock.
   always_comb begin
      error_d = timeout_expire;
   end

   // Abort pulse register.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign o_error = error_q;
`else
   assign timeout_expire = 1'b0;
   assign o_error        = 1'b0;
`endif

   // Frame FSM: next state, operand/opcode loads, result capture, start strobe.
   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_rx_valid) begin
               alu_a_d = i_rx_data[NB_AB-1:0];
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (i_rx_valid) begin
               alu_b_d = i_rx_data[NB_AB-1:0];
               state_d = WAIT_OP;
            end else if (timeout_expire) begin
               state_d = IDLE;
            end
         end
         WAIT_OP: begin
            if (i_rx_valid) begin
               alu_op_d = i_rx_data[NB_OP-1:0];
               state_d  = EXEC;
            end else if (timeout_expire) begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            // ALU has had a full cycle with stable inputs; capture its result
            // and raise the start strobe for the single SEND cycle.
            tx_data_d  = NB_DATA'(i_alu_result);
            tx_start_d = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any partial frame.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed testbench for alu_ctrl with a behavioural ALU attached.
// The timeout scenario checks expiry when ALU_CTRL_TIMEOUT_EN is defined and
// checks the wait-forever behaviour otherwise.
module tb_alu_ctrl;
   import alu_ctrl_pkg::*;

   localparam int NB_DATA = 8;
   localparam int NB_AB   = 4;
   localparam int NB_OP   = 6;
   localparam int TMO     = 16;

   logic               clock = 1'b0;
   logic               i_reset;
   logic [NB_DATA-1:0] i_rx_data;
   logic               i_rx_valid;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_tx_start;
   logic               i_tx_done;
   logic [NB_AB-1:0]   o_alu_a;
   logic [NB_AB-1:0]   o_alu_b;
   logic [NB_OP-1:0]   o_alu_op;
   logic [NB_AB-1:0]   i_alu_result;
   logic               o_busy;
   logic               o_error;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   alu_ctrl #(
      .NB_DATA        (NB_DATA),
      .NB_AB          (NB_AB),
      .NB_OP          (NB_OP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock        (clock),
      .i_reset      (i_reset),
      .i_rx_data    (i_rx_data),
      .i_rx_valid   (i_rx_valid),
      .o_tx_data    (o_tx_data),
      .o_tx_start   (o_tx_start),
      .i_tx_done    (i_tx_done),
      .o_alu_a      (o_alu_a),
      .o_alu_b      (o_alu_b),
      .o_alu_op     (o_alu_op),
      .i_alu_result (i_alu_result),
      .o_busy       (o_busy),
      .o_error      (o_error)
   );

   // Behavioural ALU driven by the controller's operand/opcode outputs.
   always_comb begin
      i_alu_result = '0;
      case (o_alu_op)
         OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
         OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
         OP_AND:  i_alu_result = o_alu_a & o_alu_b;
         OP_OR:   i_alu_result = o_alu_a | o_alu_b;
         OP_XOR:  i_alu_result = o_alu_a ^ o_alu_b;
         OP_SRA:  i_alu_result = $signed(o_alu_a) >>> o_alu_b;
         OP_SRL:  i_alu_result = o_alu_a >> o_alu_b;
         OP_NOR:  i_alu_result = ~(o_alu_a | o_alu_b);
         default: i_alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One-cycle receive strobe; returns 1 time unit after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick(1);
      i_rx_valid = 1'b0;
      i_rx_data  = '0;
   endtask

   task automatic pulse_done();
      i_tx_done = 1'b1;
      tick(1);
      i_tx_done = 1'b0;
   endtask

   // Sends a full frame and checks start latency, result and strobe width,
   // leaving the DUT in WAIT_DONE.
   task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp);
      send_byte(a);
      send_byte(b);
      send_byte(op);
      check({tag, "_start_exec"}, o_tx_start, 0);
      tick(1);
      check({tag, "_start"}, o_tx_start, 1);
      check({tag, "_data"}, o_tx_data, exp);
      tick(1);
      check({tag, "_start_1cyc"}, o_tx_start, 0);
      check({tag, "_busy_wait"}, o_busy, 1);
      $display("frame %s a=%02h b=%02h op=%02h -> tx_data=%02h", tag, a, b, op, o_tx_data);
   endtask

   // Global safety net against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int err_cnt;
      int err_first;
      int start_cnt;

      i_reset    = 1'b0;
      i_rx_data  = '0;
      i_rx_valid = 1'b0;
      i_tx_done  = 1'b0;
      tick(3);

      // Reset state
      check("rst_a", o_alu_a, 0);
      check("rst_b", o_alu_b, 0);
      check("rst_op", o_alu_op, 0);
      check("rst_txd", o_tx_data, 0);
      check("rst_start", o_tx_start, 0);
      check("rst_busy", o_busy, 0);
      check("rst_err", o_error, 0);
      $display("reset released");
      i_reset = 1'b1;
      tick(1);

      // ADD 3+5
      frame("add", 8'h03, 8'h05, 8'h20, 8'h08);
      pulse_done();
      check("add_idle", o_busy, 0);
      check("add_keep_a", o_alu_a, 4'h3);
      check("add_keep_op", o_alu_op, 6'h20);

      // SUB 2-3 wraps to F
      frame("sub", 8'h02, 8'h03, 8'h22, 8'h0F);
      pulse_done();
      check("sub_idle", o_busy, 0);

      // OR with truncated operands
      frame("or", 8'hA7, 8'h51, 8'h25, 8'h07);
      check("or_a", o_alu_a, 4'h7);
      check("or_b", o_alu_b, 4'h1);
      pulse_done();
      tick(2);
      check("or_keep_txd", o_tx_data, 8'h07);

      // Bytes arriving while busy are dropped
      frame("drop", 8'h03, 8'h05, 8'h20, 8'h08);
      send_byte(8'h09);
      check("drop_busy", o_busy, 1);
      check("drop_a1", o_alu_a, 4'h3);
      i_rx_data  = 8'h09;
      i_rx_valid = 1'b1;
      i_tx_done  = 1'b1;
      tick(1);
      i_rx_valid = 1'b0;
      i_tx_done  = 1'b0;
      i_rx_data  = '0;
      check("drop_idle", o_busy, 0);
      check("drop_a2", o_alu_a, 4'h3);
      $display("busy-drop bytes sent, state idle=%0d", !o_busy);
      tick(1);
      frame("after_drop", 8'h01, 8'h02, 8'h20, 8'h03);
      check("after_drop_a", o_alu_a, 4'h1);
      pulse_done();

      // tx_done outside WAIT_DONE is ignored
      send_byte(8'h01);
      pulse_done();
      check("done_ign_busy", o_busy, 1);
      send_byte(8'h02);
      check("done_ign_b", o_alu_b, 4'h2);
      send_byte({2'b00, OP_NOR});
      tick(1);
      check("nor_start", o_tx_start, 1);
      check("nor_data", o_tx_data, 8'h0C);
      $display("nor frame -> tx_data=%02h", o_tx_data);
      tick(1);
      pulse_done();

      // XOR and SRL, SRA
      frame("xor", 8'h0C, 8'h0A, 8'h26, 8'h06);
      pulse_done();
      frame("srl", 8'h08, 8'h02, 8'h02, 8'h02);
      pulse_done();
      frame("sra", 8'h08, 8'h02, 8'h03, 8'h0E);
      pulse_done();

      // Inter-byte timeout
      send_byte(8'h04);
      err_cnt   = 0;
      err_first = -1;
      for (int i = 1; i <= 24; i++) begin
         tick(1);
         if (o_error === 1'b1) begin
            err_cnt++;
            if (err_first < 0) err_first = i;
         end
      end
`ifdef ALU_CTRL_TIMEOUT_EN
      check("tmo_pulses", err_cnt, 1);
      check("tmo_when", err_first, 16);
      check("tmo_busy", o_busy, 0);
      check("tmo_keep_a", o_alu_a, 4'h4);
      $display("timeout: %0d error pulse(s), first after %0d idle cycles", err_cnt, err_first);
`else
      check("notmo_pulses", err_cnt, 0);
      check("notmo_busy", o_busy, 1);
      $display("no timeout build: still waiting, error pulses=%0d", err_cnt);
      i_reset = 1'b0;
      tick(1);
      i_reset = 1'b1;
`endif

      // Mid-frame reset in WAIT_OP
      send_byte(8'h05);
      send_byte(8'h06);
      check("mrst_pre_busy", o_busy, 1);
      i_reset = 1'b0;
      tick(1);
      i_reset = 1'b1;
      check("mrst_a", o_alu_a, 0);
      check("mrst_b", o_alu_b, 0);
      check("mrst_op", o_alu_op, 0);
      check("mrst_txd", o_tx_data, 0);
      check("mrst_busy", o_busy, 0);
      start_cnt = 0;
      err_cnt   = 0;
      for (int i = 0; i < 6; i++) begin
         if (o_tx_start === 1'b1) start_cnt++;
         if (o_error === 1'b1) err_cnt++;
         tick(1);
      end
      check("mrst_no_start", start_cnt, 0);
      check("mrst_no_err", err_cnt, 0);
      $display("mid-frame reset: starts=%0d errors=%0d", start_cnt, err_cnt);

      frame("post_rst", 8'h06, 8'h03, 8'h24, 8'h02);
      pulse_done();
      check("post_rst_idle", o_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
